// File: rtl/min_finder_pkg.sv
// Shared types and default sizing for the stream minimum finder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package min_finder_pkg;

    // Default element width and maximum compared elements per frame
    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_MAX_LEN = 16;

    // Frame FSM: collecting beats, then presenting a result until consumed
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } fsm_state_e;

endpackage

// File: rtl/min_select.sv
// Decides whether a candidate element replaces the running minimum.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller gates the result with its own accept.
module min_select #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] candidate,
    input  logic [WIDTH-1:0] current_min,
    output logic             take
);

    // Strict less-than, so equal values never displace an earlier minimum
    always_comb begin
        take = (candidate < current_min);
    end

endmodule

// File: rtl/stream_min_finder.sv
// Finds min value, its position and element count of each in_last-terminated frame.
// Latency: result (out_valid) one cycle after the in_last beat is accepted.
// Backpressure: in_ready low while a result waits for out_ready; one bubble per frame.
// Build option: define MIN_FINDER_INDEX_EN to build the index register; otherwise out_idx is 0.
module stream_min_finder
    import min_finder_pkg::*;
#(
    parameter  int WIDTH   = DEFAULT_WIDTH,
    parameter  int MAX_LEN = DEFAULT_MAX_LEN,
    localparam int IDX_W   = $clog2(MAX_LEN),
    localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [IDX_W-1:0] out_idx,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow,
    output logic             out_valid,
    input  logic             out_ready
);

    fsm_state_e       state_q;
    logic             run_q;      // low during reset and its first clock, keeps in_ready off
    logic [WIDTH-1:0] min_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             accept;
    logic             below_max;
    logic             take;

    // Handshake decode uses registered state only, no input-to-output path
    always_comb begin
        in_ready  = run_q && (state_q != ST_HOLD);
        out_valid = (state_q == ST_HOLD);
        accept    = in_valid && in_ready;
        below_max = (cnt_q < CNT_W'(MAX_LEN));
    end

    min_select #(
        .WIDTH (WIDTH)
    ) u_min_select (
        .candidate   (in_data),
        .current_min (min_q),
        .take        (take)
    );

    // Enable input acceptance from the first clock edge after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Frame FSM: IDLE -> ACCUM on first beat, HOLD after in_last, IDLE on consume
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= in_last ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept && in_last) begin
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Running min, count and overflow; beats past MAX_LEN only set overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            if (state_q == ST_IDLE) begin
                min_q <= in_data;
                cnt_q <= CNT_W'(1);
                ovf_q <= 1'b0;
            end else if (below_max) begin
                if (take) begin
                    min_q <= in_data;
                end
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                ovf_q <= 1'b1;
            end
        end
    end

`ifdef MIN_FINDER_INDEX_EN
    logic [IDX_W-1:0] idx_q;

    // Position of the minimum; cnt_q is the zero-based index of the incoming beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else if (accept) begin
            if (state_q == ST_IDLE) begin
                idx_q <= '0;
            end else if (below_max && take) begin
                idx_q <= cnt_q[IDX_W-1:0];
            end
        end
    end

    assign out_idx = idx_q;
`else
    assign out_idx = '0;
`endif

    assign out_min      = min_q;
    assign out_count    = cnt_q;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_stream_min_finder.sv
module tb_stream_min_finder;

    localparam int W    = 8;
    localparam int MAXL = 16;

    typedef struct {
        logic [7:0] mn;
        logic [3:0] idx;
        logic [4:0] cnt;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [7:0] out_min;
    logic [3:0] out_idx;
    logic [4:0] out_count;
    logic       out_overflow;
    logic       out_valid;
    logic       out_ready = 1'b0;

    int   tests = 0;
    int   fails = 0;
    int   hs_cnt = 0;
    int   n_pushed = 0;
    exp_t sb[$];
    logic [7:0] fr[32];
    int   fr_len = 0;

    stream_min_finder #(.WIDTH(W), .MAX_LEN(MAXL)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_min      (out_min),
        .out_idx      (out_idx),
        .out_count    (out_count),
        .out_overflow (out_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) hs_cnt <= hs_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] idx_exp(input int i);
`ifdef MIN_FINDER_INDEX_EN
        return 4'(i);
`else
        return 4'd0;
`endif
    endfunction

    // Reference model over fr[0..fr_len-1]
    function automatic exp_t model();
        exp_t e;
        e.mn = fr[0]; e.idx = 4'd0; e.cnt = 5'd1; e.ovf = 1'b0;
        for (int k = 1; k < fr_len; k++) begin
            if (k < MAXL) begin
                if (fr[k] < e.mn) begin
                    e.mn  = fr[k];
                    e.idx = 4'(k);
                end
                e.cnt = 5'(k + 1);
            end else begin
                e.ovf = 1'b1;
            end
        end
`ifndef MIN_FINDER_INDEX_EN
        e.idx = 4'd0;
`endif
        return e;
    endfunction

    function automatic exp_t mk(input logic [7:0] mn, input logic [3:0] idx,
                                input logic [4:0] cnt, input logic ovf);
        exp_t e;
        e.mn = mn; e.idx = idx; e.cnt = cnt; e.ovf = ovf;
        return e;
    endfunction

    task automatic push_exp(input exp_t e);
        sb.push_back(e);
        n_pushed++;
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted
    task automatic send(input logic [7:0] d, input logic l, input int gap);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = l;
        for (int t = 0; t < 50 && !in_ready; t++) @(negedge clk);
        if (in_ready !== 1'b1) check("send_ready_timeout", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_frame(input int gap_max);
        for (int k = 0; k < fr_len; k++)
            send(fr[k], k == fr_len - 1, gap_max > 0 ? $urandom_range(0, gap_max) : 0);
        check("latency_out_valid", out_valid, 1);
    endtask

    task automatic collect(input string tag);
        exp_t e;
        for (int t = 0; t < 100 && !out_valid; t++) @(negedge clk);
        if (out_valid !== 1'b1) begin
            check({tag, "_result_timeout"}, out_valid, 1);
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_min"},   out_min,      e.mn);
            check({tag, "_idx"},   out_idx,      e.idx);
            check({tag, "_count"}, out_count,    e.cnt);
            check({tag, "_ovf"},   out_overflow, e.ovf);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check({tag, "_valid_drop"}, out_valid, 0);
        end
    endtask

    initial begin
        exp_t e;
        int   hs_before;

        // Reset state, applied asynchronously
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_min", out_min, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_ovf", out_overflow, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // Frame 9,3,7,3: tie keeps earliest index
        fr_len = 4; fr[0] = 8'd9; fr[1] = 8'd3; fr[2] = 8'd7; fr[3] = 8'd3;
        push_exp(mk(8'd3, idx_exp(1), 5'd4, 1'b0));
        send_frame(0);
        collect("f9373");

        // Single beat 0xFF
        fr_len = 1; fr[0] = 8'hFF;
        push_exp(mk(8'hFF, 4'd0, 5'd1, 1'b0));
        send_frame(0);
        collect("single");

        // 18 beats, beat 17 is 0 but past MAX_LEN
        fr_len = 18;
        for (int k = 0; k < 16; k++) fr[k] = 8'(200 - k * 5);
        fr[10] = 8'd7; fr[16] = 8'd0; fr[17] = 8'd1;
        push_exp(mk(8'd7, idx_exp(10), 5'd16, 1'b1));
        send_frame(0);
        collect("ovf");

        // Stall in HOLD for 5 cycles with the next frame's first beat waiting
        fr_len = 3; fr[0] = 8'd40; fr[1] = 8'd20; fr[2] = 8'd30;
        push_exp(mk(8'd20, idx_exp(1), 5'd3, 1'b0));
        send_frame(0);
        in_valid = 1'b1; in_data = 8'd11; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_min", out_min, 8'd20);
            check("stall_count", out_count, 5'd3);
            @(negedge clk);
        end
        e = sb.pop_front();
        check("stall_idx", out_idx, e.idx);
        check("stall_ovf", out_overflow, e.ovf);
        hs_before = hs_cnt;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("stall_hs", hs_cnt - hs_before, 1);
        check("bubble_in_ready_idle", in_ready, 1);
        fr_len = 3; fr[0] = 8'd11; fr[1] = 8'd60; fr[2] = 8'd11;
        push_exp(model());
        send_frame(0);
        collect("after_stall");

        // Random frames with input gaps
        for (int f = 0; f < 4; f++) begin
            fr_len = $urandom_range(1, 12);
            for (int k = 0; k < fr_len; k++) fr[k] = 8'($urandom_range(0, 255));
            if (fr_len > 3) fr[fr_len - 1] = fr[1];
            push_exp(model());
            send_frame(2);
            collect("rand");
        end

        // Reset after 2 of 4 beats, then frame 5,2
        send(8'd8, 1'b0, 0);
        send(8'd6, 1'b0, 0);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_count", out_count, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        hs_before = hs_cnt;
        fr_len = 2; fr[0] = 8'd5; fr[1] = 8'd2;
        push_exp(mk(8'd2, idx_exp(1), 5'd2, 1'b0));
        send_frame(0);
        collect("after_midrst");
        check("midrst_one_result", hs_cnt - hs_before, 1);

        // Reset while holding a result discards it
        send(8'd77, 1'b1, 0);
        check("holdrst_pre_valid", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        check("holdrst_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("holdrst_no_result", out_valid, 0);
        out_ready = 1'b0;

        check("total_results", hs_cnt, n_pushed);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
